// File: rtl/sequence_led_driver.sv
// sequence_led_driver
//   Playback side of the memory-sequence game. One-cycle symbol strobes are
//   queued in a small FIFO and replayed one at a time: the symbol's LED is lit
//   for ON_CYCLES, then all LEDs are dark for GAP_CYCLES.
//
//   state | meaning
//   IDLE  | nothing playing; pops the FIFO head as soon as it is non-empty
//   ON    | one-hot LED lit, timer counting down the ON window
//   GAP   | all LEDs dark, timer counting down the gap; then next symbol or IDLE
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-low reset
//   Pin      in   symbol strobe (each high cycle is one strobe)
//   Sym      in   symbol, sampled only when Pin=1
//   Clr      in   synchronous flush, wins over Pin
//   Led      out  registered one-hot LED drive, zero when dark
//   Busy     out  FSM not IDLE or FIFO non-empty
//   Full     out  FIFO holds DEPTH entries
//   Overflow out  sticky: a strobe was dropped
//   Done     out  one-cycle pulse when playback drains back to IDLE
module sequence_led_driver #(
  parameter int SYM_W      = 2,
  parameter int DEPTH      = 4,
  parameter int ON_CYCLES  = 25000000,
  parameter int GAP_CYCLES = 12500000,
  parameter int CNT_W      = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Pin,
  input  logic [SYM_W-1:0]      Sym,
  input  logic                  Clr,
  output logic [2**SYM_W-1:0]   Led,
  output logic                  Busy,
  output logic                  Full,
  output logic                  Overflow,
  output logic                  Done
);

  localparam int NUM_LEDS = 2**SYM_W;
  localparam int PTR_W    = $clog2(DEPTH);
  localparam int CW       = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

  state_t               state, state_d;
  logic [CNT_W-1:0]     timer, timer_d;
  logic [NUM_LEDS-1:0]  led_d;
  logic                 done_d;
  logic                 pop, push, drop;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic [SYM_W-1:0]     mem [DEPTH];
  logic [NUM_LEDS-1:0]  head_onehot;

  assign Full = (count == CW'(DEPTH));
  assign Busy = (state != IDLE) || (count != '0);

  // A pop in the same edge frees a slot, so a strobe is still accepted when Full.
  assign push = Pin && (!Full || pop);
  assign drop = Pin && Full && !pop;

  always_comb begin
    head_onehot = '0;
    head_onehot[mem[rd_ptr]] = 1'b1;
  end

  always_comb begin
    state_d = state;
    timer_d = timer;
    led_d   = Led;
    done_d  = 1'b0;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          led_d   = head_onehot;
          timer_d = CNT_W'(ON_CYCLES - 1);
          state_d = ON;
        end
      end
      ON: begin
        if (timer != '0) begin
          timer_d = timer - CNT_W'(1);
        end else begin
          led_d   = '0;
          timer_d = CNT_W'(GAP_CYCLES - 1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (timer != '0) begin
          timer_d = timer - CNT_W'(1);
        end else if (count != '0) begin
          pop     = 1'b1;
          led_d   = head_onehot;
          timer_d = CNT_W'(ON_CYCLES - 1);
          state_d = ON;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      timer    <= '0;
      Led      <= '0;
      Done     <= 1'b0;
      Overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (Clr) begin
      state    <= IDLE;
      timer    <= '0;
      Led      <= '0;
      Done     <= 1'b0;
      Overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state <= state_d;
      timer <= timer_d;
      Led   <= led_d;
      Done  <= done_d;
      if (drop) Overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only entries below count are ever read.
  always_ff @(posedge clk) begin
    if (push && !Clr) mem[wr_ptr] <= Sym;
  end

endmodule

// File: tb/tb_sequence_led_driver.sv
module tb_sequence_led_driver;
  localparam int ON_C  = 4;
  localparam int GAP_C = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       Pin = 1'b0;
  logic       Clr = 1'b0;
  logic [1:0] Sym = 2'd0;
  logic [3:0] Led;
  logic       Busy, Full, Overflow, Done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int played   = 0;
  int dones    = 0;
  int p0, d0;
  logic [1:0] exp_q[$];
  logic clr_seen = 1'b0;

  sequence_led_driver #(
    .SYM_W(2), .DEPTH(4), .ON_CYCLES(ON_C), .GAP_CYCLES(GAP_C), .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst), .Pin(Pin), .Sym(Sym), .Clr(Clr),
    .Led(Led), .Busy(Busy), .Full(Full), .Overflow(Overflow), .Done(Done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [1:0] s, input bit accept);
    Pin = 1'b1;
    Sym = s;
    if (accept) exp_q.push_back(s);
    step();
    Pin = 1'b0;
    Sym = 2'($urandom_range(3, 0));
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (Busy && k < 200) begin
      step();
      k++;
    end
    chk(tag, 32'(k < 200), 1);
    step();
    step();
  endtask

  // Scoreboard monitor: pops an expected symbol each time an LED lights and
  // checks ON window and gap lengths.
  initial forever begin
    @(posedge clk);
    clr_seen = Clr;
  end

  initial begin : monitor
    logic [3:0] prev;
    logic [1:0] s;
    int run, dark;
    bit gap_act;
    prev = '0; run = 0; dark = 0; gap_act = 0;
    forever begin
      @(negedge clk);
      if (!rst || clr_seen) begin
        prev = '0; run = 0; dark = 0; gap_act = 0;
      end else begin
        if (Done) dones++;
        if (Led != '0) begin
          chk("onehot", $countones(Led), 1);
          if (prev == '0) begin
            if (gap_act) chk("gap_len", dark, GAP_C);
            gap_act = 0;
            if (exp_q.size() == 0) chk("unexpected_sym", 32'(Led), 0);
            else begin
              s = exp_q.pop_front();
              chk("sym", 32'(Led), 32'(4'b0001 << s));
            end
            played++;
            run = 1;
          end else begin
            run++;
          end
        end else begin
          if (prev != '0) begin
            chk("on_len", run, ON_C);
            gap_act = 1;
            dark = 1;
          end else if (gap_act) begin
            if (Done) begin
              chk("gap_len_done", dark, GAP_C);
              gap_act = 0;
            end else begin
              dark++;
            end
          end
        end
        prev = Led;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // 1: reset state, then async reset mid-ON
    #2 rst = 1'b0;
    step(); step();
    chk("rst_led", 32'(Led), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_full", 32'(Full), 0);
    chk("rst_ovf", 32'(Overflow), 0);
    chk("rst_done", 32'(Done), 0);
    rst = 1'b1;
    step(); step(); step();
    chk("idle_led", 32'(Led), 0);
    chk("idle_busy", 32'(Busy), 0);
    strobe(2'd2, 1);
    step(); step();
    chk("midon_led", 32'(Led), 32'h4);
    #2 rst = 1'b0;
    #1;
    chk("async_led", 32'(Led), 0);
    chk("async_busy", 32'(Busy), 0);
    chk("async_full", 32'(Full), 0);
    chk("async_ovf", 32'(Overflow), 0);
    chk("async_done", 32'(Done), 0);
    exp_q.delete();
    step();
    rst = 1'b1;
    step(); step(); step();
    chk("post_rst_led", 32'(Led), 0);
    chk("post_rst_busy", 32'(Busy), 0);

    // 2: single symbol, exact timing
    p0 = played; d0 = dones;
    strobe(2'd2, 1);
    chk("t2_busy_push", 32'(Busy), 1);
    chk("t2_led_e0", 32'(Led), 0);
    for (int i = 0; i < ON_C; i++) begin
      step();
      chk("t2_led_on", 32'(Led), 32'h4);
      chk("t2_busy_on", 32'(Busy), 1);
    end
    for (int i = 0; i < GAP_C; i++) begin
      step();
      chk("t2_led_gap", 32'(Led), 0);
      chk("t2_busy_gap", 32'(Busy), 1);
      chk("t2_done_gap", 32'(Done), 0);
    end
    step();
    chk("t2_done", 32'(Done), 1);
    chk("t2_busy_end", 32'(Busy), 0);
    step();
    chk("t2_done_fall", 32'(Done), 0);
    step();
    chk("t2_played", played - p0, 1);
    chk("t2_dones", dones - d0, 1);

    // 3: three back-to-back symbols
    p0 = played; d0 = dones;
    strobe(2'd0, 1);
    strobe(2'd1, 1);
    strobe(2'd3, 1);
    wait_idle("t3_timeout");
    chk("t3_played", played - p0, 3);
    chk("t3_dones", dones - d0, 1);

    // 4: six strobes while IDLE, sixth dropped
    p0 = played; d0 = dones;
    strobe(2'd0, 1);
    strobe(2'd1, 1);
    strobe(2'd2, 1);
    strobe(2'd3, 1);
    strobe(2'd1, 1);
    chk("t4_full", 32'(Full), 1);
    chk("t4_ovf_pre", 32'(Overflow), 0);
    strobe(2'd2, 0);
    chk("t4_full_after", 32'(Full), 1);
    chk("t4_ovf", 32'(Overflow), 1);
    wait_idle("t4_timeout");
    chk("t4_ovf_sticky", 32'(Overflow), 1);
    chk("t4_played", played - p0, 5);
    chk("t4_dones", dones - d0, 1);
    chk("t4_queue_drained", exp_q.size(), 0);
    Clr = 1'b1;
    step();
    Clr = 1'b0;
    chk("clr_ovf", 32'(Overflow), 0);

    // 5: strobe on the GAP->ON pop edge while Full
    p0 = played; d0 = dones;
    strobe(2'd3, 1);
    strobe(2'd2, 1);
    strobe(2'd1, 1);
    strobe(2'd0, 1);
    strobe(2'd3, 1);
    step(); step();
    chk("t5_full_pre", 32'(Full), 1);
    strobe(2'd2, 1);
    chk("t5_full_post", 32'(Full), 1);
    chk("t5_ovf", 32'(Overflow), 0);
    chk("t5_led_next", 32'(Led), 32'h4);
    wait_idle("t5_timeout");
    chk("t5_played", played - p0, 6);
    chk("t5_dones", dones - d0, 1);
    chk("t5_ovf_end", 32'(Overflow), 0);

    // 6: Clr mid-ON with two queued and a strobe in the same cycle
    strobe(2'd1, 1);
    strobe(2'd2, 1);
    strobe(2'd3, 1);
    step();
    chk("t6_led_on", 32'(Led), 32'h2);
    Clr = 1'b1; Pin = 1'b1; Sym = 2'd0;
    step();
    Clr = 1'b0; Pin = 1'b0;
    exp_q.delete();
    chk("t6_led", 32'(Led), 0);
    chk("t6_busy", 32'(Busy), 0);
    chk("t6_ovf", 32'(Overflow), 0);
    chk("t6_full", 32'(Full), 0);
    chk("t6_done", 32'(Done), 0);
    step();
    p0 = played; d0 = dones;
    for (int i = 0; i < 20; i++) step();
    chk("t6_played", played - p0, 0);
    chk("t6_dones", dones - d0, 0);
    chk("t6_busy_end", 32'(Busy), 0);
    chk("final_queue", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
